// File: rtl/pia_uart_bridge.sv
// pia_uart_bridge: host terminal bridge for the Apple-1 PIA.
// UART RX -> case-mapped byte FIFO -> keyboard 4-phase handshake.
// Display 4-phase handshake -> UART TX, with optional LF after CR.
module pia_uart_bridge #(
    parameter int CLK_DIV    = 104,   // clk cycles per UART bit, >= 4
    parameter int FIFO_DEPTH = 4,     // power of 2, >= 2
    parameter bit UPCASE     = 1'b1,
    parameter bit CRLF       = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       kbd_rdy,
    input  logic       kbd_ack,
    output logic [6:0] kbd_data,
    input  logic       dsp_rdy,
    output logic       dsp_ack,
    input  logic [6:0] dsp_data,
    output logic       rx_overrun
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'((CLK_DIV >> 1) - 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {K_IDLE, K_ACK, K_REL} kbd_state_t;
    typedef enum logic [1:0] {D_IDLE, D_REL, D_LF} dsp_state_t;

    // ---------------- RX synchroniser ----------------
    logic rxd_s1_q, rxd_s2_q, rxd_s3_q;

    // two-stage synchroniser plus one delayed copy for falling-edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            rxd_s3_q <= 1'b1;
        end else begin
            rxd_s1_q <= uart_rxd;
            rxd_s2_q <= rxd_s1_q;
            rxd_s3_q <= rxd_s2_q;
        end
    end

    // ---------------- RX deserialiser ----------------
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [6:0]    rx_shift_q, rx_shift_d;   // bit7 is never stored: stripped on arrival
    logic [6:0]    rx_char;
    logic          rx_push;

    // frame sequencing; push request is raised in the stop-sample cycle
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        rx_char    = rx_shift_q;
        if (UPCASE && rx_shift_q >= 7'h61 && rx_shift_q <= 7'h7A)
            rx_char = rx_shift_q - 7'h20;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (rxd_s3_q && !rxd_s2_q) rx_state_d = R_START;
            end
            R_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s2_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        rx_shift_d = {rxd_s2_q, rx_shift_q[6:1]};
                        rx_bit_d   = rx_bit_q + 1'b1;
                    end
                end
            end
            R_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d = '0;
                    if (rxd_s2_q) begin
                        rx_state_d = R_IDLE;
                        rx_push    = (rx_shift_q != 7'h0A);
                    end else begin
                        rx_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                rx_cnt_d = '0;
                if (rxd_s2_q) rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [6:0]  fifo_mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, fifo_pop, fifo_push;
    logic        rx_overrun_q, rx_overrun_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // a same-cycle pop frees a slot, so a push into a full FIFO still lands
    always_comb begin
        fifo_push    = rx_push && (!fifo_full || fifo_pop);
        wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, fifo_push};
        rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, fifo_pop};
        rx_overrun_d = rx_overrun_q | (rx_push && fifo_full && !fifo_pop);
    end

    // FIFO pointers and sticky overrun
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    // FIFO storage; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= rx_char;
    end

    // ---------------- keyboard handshake ----------------
    kbd_state_t kbd_state_q, kbd_state_d;
    logic       kbd_rdy_q, kbd_rdy_d;
    logic [6:0] kbd_data_q, kbd_data_d;

    // 4-phase: load+rdy, wait ack high, wait ack low
    always_comb begin
        kbd_state_d = kbd_state_q;
        kbd_rdy_d   = kbd_rdy_q;
        kbd_data_d  = kbd_data_q;
        fifo_pop    = 1'b0;
        case (kbd_state_q)
            K_IDLE: begin
                if (!fifo_empty && !kbd_ack) begin
                    kbd_data_d  = fifo_mem_q[rd_ptr_q[AW-1:0]];
                    fifo_pop    = 1'b1;
                    kbd_rdy_d   = 1'b1;
                    kbd_state_d = K_ACK;
                end
            end
            K_ACK: begin
                if (kbd_ack) begin
                    kbd_rdy_d   = 1'b0;
                    kbd_state_d = K_REL;
                end
            end
            K_REL: begin
                if (!kbd_ack) kbd_state_d = K_IDLE;
            end
            default: kbd_state_d = K_IDLE;
        endcase
    end

    // keyboard state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_state_q <= K_IDLE;
            kbd_rdy_q   <= 1'b0;
            kbd_data_q  <= '0;
        end else begin
            kbd_state_q <= kbd_state_d;
            kbd_rdy_q   <= kbd_rdy_d;
            kbd_data_q  <= kbd_data_d;
        end
    end

    // ---------------- display handshake + TX ----------------
    dsp_state_t dsp_state_q, dsp_state_d;
    logic       dsp_ack_q, dsp_ack_d;
    logic       dsp_cr_q, dsp_cr_d;
    logic       tx_busy_q, tx_busy_d;
    logic       txd_q, txd_d;
    logic [8:0] tx_shift_q, tx_shift_d;     // {stop, data[7:0]}; start bit goes straight to txd
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0] tx_bit_q, tx_bit_d;
    logic       tx_last, tx_idle, tx_start;
    logic [7:0] tx_char;

    // idle already in the last stop-bit cycle so a queued frame follows with no gap
    assign tx_last = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cnt_q == DIV_LAST);
    assign tx_idle = !tx_busy_q || tx_last;

    // display FSM; dsp_rdy is simply left pending while TX is busy
    always_comb begin
        dsp_state_d = dsp_state_q;
        dsp_ack_d   = dsp_ack_q;
        dsp_cr_d    = dsp_cr_q;
        tx_start    = 1'b0;
        tx_char     = 8'h0A;
        case (dsp_state_q)
            D_IDLE: begin
                if (dsp_rdy && tx_idle) begin
                    tx_start    = 1'b1;
                    tx_char     = {1'b0, dsp_data};
                    dsp_ack_d   = 1'b1;
                    dsp_cr_d    = (dsp_data == 7'h0D);
                    dsp_state_d = D_REL;
                end
            end
            D_REL: begin
                if (!dsp_rdy) begin
                    dsp_ack_d   = 1'b0;
                    dsp_state_d = (CRLF && dsp_cr_q) ? D_LF : D_IDLE;
                end
            end
            D_LF: begin
                if (tx_idle) begin
                    tx_start    = 1'b1;
                    dsp_state_d = D_IDLE;
                end
            end
            default: dsp_state_d = D_IDLE;
        endcase
    end

    // TX serialiser: each bit held CLK_DIV cycles, txd is registered
    always_comb begin
        tx_busy_d  = tx_busy_q;
        txd_d      = txd_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        if (tx_start) begin
            tx_busy_d  = 1'b1;
            txd_d      = 1'b0;
            tx_shift_d = {1'b1, tx_char};
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == DIV_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                end else begin
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    // display and TX state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dsp_state_q <= D_IDLE;
            dsp_ack_q   <= 1'b0;
            dsp_cr_q    <= 1'b0;
            tx_busy_q   <= 1'b0;
            txd_q       <= 1'b1;
            tx_shift_q  <= '1;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
        end else begin
            dsp_state_q <= dsp_state_d;
            dsp_ack_q   <= dsp_ack_d;
            dsp_cr_q    <= dsp_cr_d;
            tx_busy_q   <= tx_busy_d;
            txd_q       <= txd_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
        end
    end

    assign uart_txd   = txd_q;
    assign kbd_rdy    = kbd_rdy_q;
    assign kbd_data   = kbd_data_q;
    assign dsp_ack    = dsp_ack_q;
    assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_pia_uart_bridge.sv
// Bench for pia_uart_bridge: randomized keyboard/display traffic checked
// against a character-level model (case map, LF drop, FIFO capacity, frames).
module tb_pia_uart_bridge;
    localparam int CLK_DIV = 8;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       kbd_ack = 1'b0;
    logic       dsp_rdy = 1'b0;
    logic [6:0] dsp_data = 7'h00;
    logic       uart_txd, kbd_rdy, dsp_ack, rx_overrun;
    logic [6:0] kbd_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pia_uart_bridge #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .UPCASE(1'b1), .CRLF(1'b1)) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .kbd_rdy(kbd_rdy), .kbd_ack(kbd_ack), .kbd_data(kbd_data),
        .dsp_rdy(dsp_rdy), .dsp_ack(dsp_ack), .dsp_data(dsp_data),
        .rx_overrun(rx_overrun)
    );

    // character the keyboard should see for a received byte, -1 if none
    function automatic int kbd_model(input int b);
        int c;
        c = b % 128;
        if (c == 10) return -1;
        if (c >= 97 && c <= 122) c = c - 32;
        return c;
    endfunction

    // line level during bit slot k (0=start, 1..8 data LSB first, 9=stop)
    function automatic logic frame_bit(input logic [7:0] c, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return c[k-1];
    endfunction

    task automatic uart_send(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (CLK_DIV) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_kbd(input string name, input int exp);
        int t;
        logic [6:0] e;
        t = 0;
        e = exp[6:0];
        while (kbd_rdy !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (kbd_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL %s: kbd_rdy timeout, got %b want 1", name, kbd_rdy);
        end else if (kbd_data !== e) begin
            n_err++;
            $display("FAIL %s: kbd_data got %h want %h", name, kbd_data, e);
        end
    endtask

    task automatic ack_kbd(input string name, input int exp);
        logic [6:0] e;
        e = exp[6:0];
        kbd_ack = 1'b1;
        @(negedge clk);
        n_vec++;
        if (kbd_rdy !== 1'b0 || kbd_data !== e) begin
            n_err++;
            $display("FAIL %s_ack: rdy/data got %b/%h want 0/%h", name, kbd_rdy, kbd_data, e);
        end
        kbd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_no_kbd(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | kbd_rdy;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL %s: kbd_rdy rose, got %b want 0", name, seen);
        end
    endtask

    // one display character, transmitter expected idle on entry
    task automatic test_display_char(input string name, input logic [6:0] c);
        logic [79:0] got, exp;
        for (int i = 0; i < 80; i++) exp[i] = frame_bit({1'b0, c}, i / CLK_DIV);
        dsp_data = c;
        dsp_rdy  = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dsp_ack !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ack_rise: got %b want 1", name, dsp_ack);
        end
        for (int i = 0; i < 80; i++) begin
            got[i] = uart_txd;
            if (i == 0) dsp_rdy = 1'b0;
            if (i == 1) begin
                n_vec++;
                if (dsp_ack !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_ack_fall: got %b want 0", name, dsp_ack);
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (got !== exp || uart_txd !== 1'b1) begin
            n_err++;
            $display("FAIL %s_frame: got %h/idle %b want %h/idle 1", name, got, uart_txd, exp);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_vec++;
        if (uart_txd !== 1'b1 || kbd_rdy !== 1'b0 || kbd_data !== 7'h00 ||
            dsp_ack !== 1'b0 || rx_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset: txd/rdy/data/ack/ovr got %b/%b/%h/%b/%b want 1/0/00/0/0",
                     uart_txd, kbd_rdy, kbd_data, dsp_ack, rx_overrun);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_kbd_basic;
        uart_send(8'h61, 1'b1);
        wait_kbd("kbd_a", kbd_model(8'h61));
        ack_kbd("kbd_a", kbd_model(8'h61));
    endtask

    task automatic test_display;
        logic [6:0] c;
        test_display_char("dsp_H", 7'h48);
        for (int i = 0; i < 3; i++) begin
            c = 7'($urandom_range(32, 126));
            test_display_char("dsp_rnd", c);
        end
    endtask

    task automatic test_crlf;
        logic [159:0] got, exp;
        logic         seen_low;
        for (int i = 0; i < 160; i++)
            exp[i] = frame_bit((i < 80) ? 8'h0D : 8'h0A, (i % 80) / CLK_DIV);
        dsp_data = 7'h0D;
        dsp_rdy  = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dsp_ack !== 1'b1) begin
            n_err++;
            $display("FAIL crlf_ack: got %b want 1", dsp_ack);
        end
        for (int i = 0; i < 160; i++) begin
            got[i] = uart_txd;
            if (i == 0) dsp_rdy = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL crlf_frames: got %h want %h", got, exp);
        end
        seen_low = 1'b0;
        for (int i = 0; i < 30; i++) begin
            seen_low = seen_low | ~uart_txd;
            @(negedge clk);
        end
        n_vec++;
        if (seen_low !== 1'b0) begin
            n_err++;
            $display("FAIL crlf_idle: extra frame after LF, low seen %b want 0", seen_low);
        end
    endtask

    // second character raised while the first is still on the wire
    task automatic test_back_to_back;
        logic [6:0]   a, b;
        logic [159:0] got, exp;
        logic         early;
        a = 7'($urandom_range(32, 126));
        b = 7'($urandom_range(32, 126));
        for (int i = 0; i < 160; i++)
            exp[i] = frame_bit((i < 80) ? {1'b0, a} : {1'b0, b}, (i % 80) / CLK_DIV);
        early    = 1'b0;
        dsp_data = a;
        dsp_rdy  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 160; i++) begin
            got[i] = uart_txd;
            if (i == 0) dsp_rdy = 1'b0;
            if (i == 1) begin
                dsp_data = b;
                dsp_rdy  = 1'b1;
            end
            if (i >= 2 && i < 80) early = early | dsp_ack;
            if (i == 80) begin
                n_vec++;
                if (dsp_ack !== 1'b1 || early !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_backpressure: ack %b early %b want 1/0", dsp_ack, early);
                end
                dsp_rdy = 1'b0;
            end
            @(negedge clk);
        end
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL b2b_frames: got %h want %h", got, exp);
        end
    endtask

    task automatic test_rx_random;
        logic [7:0] b;
        int         e;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i == 0) b = 8'h8A;   // strips to LF
            if (i == 1) b = 8'hE1;   // strips to 'a'
            if (i == 2) b = 8'h7A;
            e = kbd_model(b);
            uart_send(b, 1'b1);
            if (e < 0) begin
                expect_no_kbd("rx_rnd_drop", 20);
            end else begin
                wait_kbd("rx_rnd", e);
                ack_kbd("rx_rnd", e);
            end
        end
    endtask

    task automatic test_framing;
        uart_send(8'h55, 1'b0);
        expect_no_kbd("frame_err", 40);
        uart_send(8'h42, 1'b1);
        wait_kbd("after_frame_err", kbd_model(8'h42));
        ack_kbd("after_frame_err", kbd_model(8'h42));
        uart_send(8'h0A, 1'b1);
        expect_no_kbd("lf_drop", 40);
    endtask

    task automatic test_concurrent;
        logic [7:0] b;
        logic [6:0] c;
        b = 8'($urandom_range(32, 126));
        c = 7'($urandom_range(32, 126));
        fork
            uart_send(b, 1'b1);
            test_display_char("conc_dsp", c);
        join
        wait_kbd("conc_kbd", kbd_model(b));
        ack_kbd("conc_kbd", kbd_model(b));
    endtask

    task automatic test_overrun;
        int q[$];
        int e;
        logic exp_ovr;
        exp_ovr = 1'b0;
        // with ack held low the bridge holds one char in kbd_data plus DEPTH queued
        for (int i = 0; i < 6; i++) begin
            e = kbd_model(8'h31 + i);
            if (q.size() < DEPTH + 1) q.push_back(e);
            else exp_ovr = 1'b1;
            uart_send(8'(8'h31 + i), 1'b1);
        end
        n_vec++;
        if (rx_overrun !== exp_ovr) begin
            n_err++;
            $display("FAIL overrun_flag: got %b want %b", rx_overrun, exp_ovr);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            wait_kbd("ovr_drain", e);
            ack_kbd("ovr_drain", e);
        end
        expect_no_kbd("ovr_empty", 40);
        n_vec++;
        if (rx_overrun !== exp_ovr) begin
            n_err++;
            $display("FAIL overrun_sticky: got %b want %b", rx_overrun, exp_ovr);
        end
    endtask

    task automatic test_reset_midframe;
        uart_send(8'h62, 1'b1);
        wait_kbd("rst_pending", kbd_model(8'h62));
        dsp_data = 7'h41;          // slot 3 (data bit 2) is low at the reset point
        dsp_rdy  = 1'b1;
        uart_rxd = 1'b0;
        repeat (30) @(negedge clk);
        n_vec++;
        if (uart_txd !== 1'b0) begin
            n_err++;
            $display("FAIL rst_pre_txd: got %b want 0", uart_txd);
        end
        reset    = 1'b0;
        dsp_rdy  = 1'b0;
        uart_rxd = 1'b1;
        #1;
        n_vec++;
        if (uart_txd !== 1'b1 || dsp_ack !== 1'b0 || kbd_rdy !== 1'b0 || rx_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: txd/ack/rdy/ovr got %b/%b/%b/%b want 1/0/0/0",
                     uart_txd, dsp_ack, kbd_rdy, rx_overrun);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        expect_no_kbd("rst_no_stale", 30);
        uart_send(8'h61, 1'b1);
        wait_kbd("rst_after_rx", kbd_model(8'h61));
        ack_kbd("rst_after_rx", kbd_model(8'h61));
        test_display_char("rst_after_tx", 7'h48);
    endtask

    initial begin
        test_reset();
        test_kbd_basic();
        test_display();
        test_crlf();
        test_back_to_back();
        test_rx_random();
        test_framing();
        test_concurrent();
        test_overrun();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
